// File: rtl/lsb_param_if.sv
// -----------------------------------------------------------------------------
// lsb_param_if
//   Memory-side bus between the load/store buffer (master) and the memory
//   controller (slave). One access is outstanding at a time: the master raises
//   mem_req together with the access attributes and holds all of them stable
//   until the slave answers with a single-cycle mem_done.
//
//   mem_req    master -> slave  access request (level)
//   mem_we     master -> slave  1 = store, 0 = load
//   mem_addr   master -> slave  byte address
//   mem_len    master -> slave  00 byte, 01 half, 11 word
//   mem_wdata  master -> slave  store data
//   mem_done   slave -> master  one-cycle completion strobe
//   mem_rdata  slave -> master  load data, valid with mem_done
// -----------------------------------------------------------------------------
interface lsb_param_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_len;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    input  mem_done, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_len, mem_wdata,
    output mem_done, mem_rdata
  );
endinterface

// File: rtl/lsb_param.sv
// -----------------------------------------------------------------------------
// lsb_param
//   Parametrised in-order load/store buffer. Entries are pushed at the tail by
//   issue, wait for their operands on NUM_WB writeback channels, and execute
//   strictly from the head, one memory access at a time. Stores wait for the
//   ROB commit; loads to the I/O region wait until they reach the ROB head.
//   A flush discards all uncommitted entries; an in-flight load is drained
//   (handshake finished, result dropped) rather than abandoned.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   push*                 enqueue one entry at tail_pos
//   wb_valid/robpos/val   NUM_WB writeback channels snooped for wakeup
//   commit_valid/lsbpos   ROB marks the store at an LSB index as committed
//   rob_head_robpos       ROB tag currently at the ROB head
//   flush                 mispredict flush
//   mem                   memory controller bus (master side)
//   ld_valid/val/robpos   load result pulse with extended data and tag
//   tail_pos, count       next push index, occupied entries
//   full, almost_full     count == DEPTH, free entries <= AFULL_TH
// -----------------------------------------------------------------------------
module lsb_param #(
  parameter int          DEPTH    = 16,
  parameter int          ROB_W    = 4,
  parameter int          NUM_WB   = 2,
  parameter int          AFULL_TH = 3,
  parameter logic [31:0] IO_BASE  = 32'h0003_0000,
  localparam int         IDX_W    = $clog2(DEPTH),
  localparam int         CNT_W    = IDX_W + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     push_is_store,
  input  logic [2:0]               push_funct3,
  input  logic [31:0]              push_imm,
  input  logic [ROB_W-1:0]         push_robpos,
  input  logic [31:0]              push_vj,
  input  logic [31:0]              push_vk,
  input  logic                     push_qj,
  input  logic                     push_qk,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*ROB_W-1:0]  wb_robpos,
  input  logic [NUM_WB*32-1:0]     wb_val,
  input  logic                     commit_valid,
  input  logic [IDX_W-1:0]         commit_lsbpos,
  input  logic [ROB_W-1:0]         rob_head_robpos,
  input  logic                     flush,
  lsb_param_if.master              mem,
  output logic                     ld_valid,
  output logic [31:0]              ld_val,
  output logic [ROB_W-1:0]         ld_robpos,
  output logic [IDX_W-1:0]         tail_pos,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     almost_full
);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  // Entry storage. No reset needed: an entry is only meaningful while it lies
  // in the occupied window [head, head+count).
  logic [DEPTH-1:0] is_store_reg;
  logic [DEPTH-1:0] qj_reg;
  logic [DEPTH-1:0] qk_reg;
  logic [DEPTH-1:0] committed_reg;
  logic [2:0]       f3_reg     [DEPTH];
  logic [31:0]      imm_reg    [DEPTH];
  logic [31:0]      vj_reg     [DEPTH];
  logic [31:0]      vk_reg     [DEPTH];
  logic [ROB_W-1:0] robpos_reg [DEPTH];

  // Control state
  state_t           state_reg;
  logic [IDX_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             full_reg, almost_full_reg;
  logic             mem_req_reg, mem_we_reg;
  logic [31:0]      mem_addr_reg, mem_wdata_reg;
  logic [1:0]       mem_len_reg;
  logic             ld_valid_reg;
  logic [31:0]      ld_val_reg;
  logic [ROB_W-1:0] ld_robpos_reg;
  logic             busy_store_reg;
  logic [2:0]       busy_f3_reg;
  logic [ROB_W-1:0] busy_robpos_reg;

  // Combinational next-state
  logic [IDX_W-1:0] head_next, tail_next;
  logic [CNT_W-1:0] count_next, n_committed;
  logic [IDX_W-1:0] win_off;
  logic             push_en, retire, issue, head_ok;
  logic [31:0]      head_addr;
  logic [DEPTH-1:0] j_hit, k_hit;
  logic [31:0]      j_val [DEPTH];
  logic [31:0]      k_val [DEPTH];
  logic             push_j_hit, push_k_hit;
  logic [31:0]      push_j_val, push_k_val;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'h0, d[7:0]};
      3'b101:  return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Wakeup match. Channels are scanned from the highest index down so the
  // lowest-index channel is the last writer and wins a duplicate tag.
  always_comb begin
    j_hit      = '0;
    k_hit      = '0;
    push_j_hit = 1'b0;
    push_k_hit = 1'b0;
    push_j_val = '0;
    push_k_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      j_val[i] = '0;
      k_val[i] = '0;
      for (int ch = NUM_WB - 1; ch >= 0; ch--) begin
        if (wb_valid[ch] && wb_robpos[ch*ROB_W +: ROB_W] == vj_reg[i][ROB_W-1:0]) begin
          j_hit[i] = 1'b1;
          j_val[i] = wb_val[ch*32 +: 32];
        end
        if (wb_valid[ch] && wb_robpos[ch*ROB_W +: ROB_W] == vk_reg[i][ROB_W-1:0]) begin
          k_hit[i] = 1'b1;
          k_val[i] = wb_val[ch*32 +: 32];
        end
      end
    end
    for (int ch = NUM_WB - 1; ch >= 0; ch--) begin
      if (wb_valid[ch] && wb_robpos[ch*ROB_W +: ROB_W] == push_vj[ROB_W-1:0]) begin
        push_j_hit = push_qj;
        push_j_val = wb_val[ch*32 +: 32];
      end
      if (wb_valid[ch] && wb_robpos[ch*ROB_W +: ROB_W] == push_vk[ROB_W-1:0]) begin
        push_k_hit = push_qk;
        push_k_val = wb_val[ch*32 +: 32];
      end
    end
  end

  // Pointer / count bookkeeping and issue decision
  always_comb begin
    push_en = push && !flush;
    // A drained (flushed) load is never retired: flush already removed it.
    retire  = (state_reg == BUSY) && mem.mem_done && (busy_store_reg || !flush);

    // Committed entries form a prefix from head, so counting committed bits
    // inside the occupied window gives the length of the surviving prefix.
    n_committed = '0;
    win_off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      win_off = IDX_W'(i) - head_reg;
      if (CNT_W'(win_off) < count_reg && committed_reg[i])
        n_committed = n_committed + CNT_W'(1);
    end

    head_next = head_reg + IDX_W'(retire);
    if (flush) begin
      tail_next  = head_reg + n_committed[IDX_W-1:0];
      count_next = n_committed - CNT_W'(retire);
    end else begin
      tail_next  = tail_reg + IDX_W'(push_en);
      count_next = count_reg + CNT_W'(push_en) - CNT_W'(retire);
    end

    head_addr = vj_reg[head_reg] + imm_reg[head_reg];
    if (is_store_reg[head_reg])
      head_ok = committed_reg[head_reg];
    else
      head_ok = (head_addr < IO_BASE) || (robpos_reg[head_reg] == rob_head_robpos);
    issue = (state_reg == IDLE) && !flush && (count_reg != '0) &&
            !qj_reg[head_reg] && !qk_reg[head_reg] && head_ok;
  end

  // Entry array: push write, operand wakeup, commit marking
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_en && tail_reg == IDX_W'(i)) begin
        is_store_reg[i]  <= push_is_store;
        f3_reg[i]        <= push_funct3;
        imm_reg[i]       <= push_imm;
        robpos_reg[i]    <= push_robpos;
        vj_reg[i]        <= push_j_hit ? push_j_val : push_vj;
        vk_reg[i]        <= push_k_hit ? push_k_val : push_vk;
        qj_reg[i]        <= push_qj && !push_j_hit;
        qk_reg[i]        <= push_qk && !push_k_hit;
        committed_reg[i] <= 1'b0;
      end else if (!flush) begin
        if (qj_reg[i] && j_hit[i]) begin
          vj_reg[i] <= j_val[i];
          qj_reg[i] <= 1'b0;
        end
        if (qk_reg[i] && k_hit[i]) begin
          vk_reg[i] <= k_val[i];
          qk_reg[i] <= 1'b0;
        end
        if (commit_valid && commit_lsbpos == IDX_W'(i))
          committed_reg[i] <= 1'b1;
      end
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      mem_req_reg     <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_addr_reg    <= '0;
      mem_len_reg     <= '0;
      mem_wdata_reg   <= '0;
      ld_valid_reg    <= 1'b0;
      ld_val_reg      <= '0;
      ld_robpos_reg   <= '0;
      busy_store_reg  <= 1'b0;
      busy_f3_reg     <= '0;
      busy_robpos_reg <= '0;
    end else begin
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      count_reg       <= count_next;
      full_reg        <= (count_next == CNT_W'(DEPTH));
      almost_full_reg <= ((CNT_W'(DEPTH) - count_next) <= CNT_W'(AFULL_TH));
      ld_valid_reg    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue) begin
            state_reg       <= BUSY;
            mem_req_reg     <= 1'b1;
            mem_we_reg      <= is_store_reg[head_reg];
            mem_addr_reg    <= head_addr;
            mem_len_reg     <= f3_reg[head_reg][1] ? 2'b11 : {1'b0, f3_reg[head_reg][0]};
            mem_wdata_reg   <= vk_reg[head_reg];
            busy_store_reg  <= is_store_reg[head_reg];
            busy_f3_reg     <= f3_reg[head_reg];
            busy_robpos_reg <= robpos_reg[head_reg];
          end
        end
        BUSY: begin
          if (mem.mem_done) begin
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
            if (!busy_store_reg && !flush) begin
              ld_valid_reg  <= 1'b1;
              ld_val_reg    <= load_extend(busy_f3_reg, mem.mem_rdata);
              ld_robpos_reg <= busy_robpos_reg;
            end
          end else if (flush && !busy_store_reg) begin
            // Loads are never committed: finish the handshake, drop the data.
            state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem.mem_done) begin
            mem_req_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_len   = mem_len_reg;
  assign mem.mem_wdata = mem_wdata_reg;
  assign ld_valid      = ld_valid_reg;
  assign ld_val        = ld_val_reg;
  assign ld_robpos     = ld_robpos_reg;
  assign tail_pos      = tail_reg;
  assign count         = count_reg;
  assign full          = full_reg;
  assign almost_full   = almost_full_reg;

endmodule

// File: tb/tb_lsb_param.sv
// -----------------------------------------------------------------------------
// tb_lsb_param
//   Directed bench for lsb_param. The bench plays issue, ROB, writeback and
//   memory controller; every expected value is a hand-computed constant or a
//   simple tail-pointer model kept by the bench.
// -----------------------------------------------------------------------------
module tb_lsb_param;
  localparam int          DEPTH    = 16;
  localparam int          ROB_W    = 4;
  localparam int          NUM_WB   = 2;
  localparam int          AFULL_TH = 3;
  localparam logic [31:0] IO_BASE  = 32'h0003_0000;
  localparam int          IDX_W    = $clog2(DEPTH);
  localparam int          CNT_W    = IDX_W + 1;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    push, push_is_store, push_qj, push_qk;
  logic [2:0]              push_funct3;
  logic [31:0]             push_imm, push_vj, push_vk;
  logic [ROB_W-1:0]        push_robpos;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*ROB_W-1:0] wb_robpos;
  logic [NUM_WB*32-1:0]    wb_val;
  logic                    commit_valid;
  logic [IDX_W-1:0]        commit_lsbpos;
  logic [ROB_W-1:0]        rob_head_robpos;
  logic                    flush;
  logic                    ld_valid;
  logic [31:0]             ld_val;
  logic [ROB_W-1:0]        ld_robpos;
  logic [IDX_W-1:0]        tail_pos;
  logic [CNT_W-1:0]        count;
  logic                    full, almost_full;

  lsb_param_if mem_bus ();

  lsb_param #(
    .DEPTH(DEPTH), .ROB_W(ROB_W), .NUM_WB(NUM_WB),
    .AFULL_TH(AFULL_TH), .IO_BASE(IO_BASE)
  ) dut (
    .clk(clk), .reset(reset),
    .push(push), .push_is_store(push_is_store), .push_funct3(push_funct3),
    .push_imm(push_imm), .push_robpos(push_robpos),
    .push_vj(push_vj), .push_vk(push_vk), .push_qj(push_qj), .push_qk(push_qk),
    .wb_valid(wb_valid), .wb_robpos(wb_robpos), .wb_val(wb_val),
    .commit_valid(commit_valid), .commit_lsbpos(commit_lsbpos),
    .rob_head_robpos(rob_head_robpos), .flush(flush),
    .mem(mem_bus),
    .ld_valid(ld_valid), .ld_val(ld_val), .ld_robpos(ld_robpos),
    .tail_pos(tail_pos), .count(count), .full(full), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_tail = 0;

  // Pushing into a full buffer is illegal stimulus.
  always @(posedge clk) begin
    if (reset && push && !flush)
      assert (!full) else $error("push issued while buffer full");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Inputs change at the current negedge; the entry lands on the next posedge.
  task automatic push_op(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                         input logic [ROB_W-1:0] rp, input logic [31:0] vj,
                         input logic [31:0] vk, input logic qj, input logic qk);
    push = 1'b1; push_is_store = st; push_funct3 = f3; push_imm = imm;
    push_robpos = rp; push_vj = vj; push_vk = vk; push_qj = qj; push_qk = qk;
    @(negedge clk);
    push = 1'b0;
    exp_tail = (exp_tail + 1) % DEPTH;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!mem_bus.mem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_req"}, 32'(mem_bus.mem_req), 32'd1);
  endtask

  task automatic no_req(input string tag, input int cycles);
    logic seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (mem_bus.mem_req) seen = 1'b1;
    end
    check_eq(tag, 32'(seen), 32'd0);
  endtask

  task automatic mem_complete(input logic [31:0] rdata);
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_rdata = rdata;
    @(negedge clk);
    mem_bus.mem_done = 1'b0;
  endtask

  // Load extension vectors: funct3, raw read data, extended result
  logic [2:0]  lt_f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] lt_rd  [4] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_8001, 32'h0000_8001};
  logic [31:0] lt_exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset = 1'b0; push = 1'b0; push_is_store = 1'b0; push_funct3 = '0; push_imm = '0;
    push_robpos = '0; push_vj = '0; push_vk = '0; push_qj = 1'b0; push_qk = 1'b0;
    wb_valid = '0; wb_robpos = '0; wb_val = '0; commit_valid = 1'b0; commit_lsbpos = '0;
    rob_head_robpos = '0; flush = 1'b0;
    mem_bus.mem_done = 1'b0; mem_bus.mem_rdata = '0;

    // ---- reset state, then reset mid-access ----
    repeat (3) @(negedge clk);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("rst_afull", 32'(almost_full), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    push_op(1'b0, 3'b010, 32'h0, 4'd1, 32'h40, 32'h0, 1'b0, 1'b0);
    wait_req("pre_rst");
    reset = 1'b0;
    #1;
    check_eq("midrst_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("midrst_count", 32'(count), 32'd0);
    check_eq("midrst_tail", 32'(tail_pos), 32'd0);
    check_eq("midrst_addr", mem_bus.mem_addr, 32'd0);
    check_eq("midrst_ldv", 32'(ld_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_tail = 0;
    @(negedge clk);
    check_eq("post_rst_req", 32'(mem_bus.mem_req), 32'd0);

    // ---- plain LW ----
    push_op(1'b0, 3'b010, 32'h4, 4'd3, 32'h100, 32'h0, 1'b0, 1'b0);
    wait_req("lw");
    check_eq("lw_addr", mem_bus.mem_addr, 32'h104);
    check_eq("lw_len", 32'(mem_bus.mem_len), 32'd3);
    check_eq("lw_we", 32'(mem_bus.mem_we), 32'd0);
    @(negedge clk);
    mem_complete(32'hDEAD_BEEF);
    check_eq("lw_ldv", 32'(ld_valid), 32'd1);
    check_eq("lw_val", ld_val, 32'hDEAD_BEEF);
    check_eq("lw_tag", 32'(ld_robpos), 32'd3);
    check_eq("lw_req_drop", 32'(mem_bus.mem_req), 32'd0);
    @(negedge clk);
    check_eq("lw_ldv_pulse", 32'(ld_valid), 32'd0);
    check_eq("lw_count", 32'(count), 32'd0);

    // ---- B/BU/H/HU with same-cycle writeback forwarding on channel 1 ----
    for (int i = 0; i < 4; i++) begin
      wb_valid = 2'b11;
      wb_robpos = {4'd5, 4'd6};
      wb_val = {32'h0000_0200, 32'h0000_0BAD};
      push_op(1'b0, lt_f3[i], 32'h10, 4'(8 + i), 32'd5, 32'h0, 1'b1, 1'b0);
      wb_valid = '0;
      wait_req($sformatf("ext%0d", i));
      check_eq($sformatf("ext%0d_addr", i), mem_bus.mem_addr, 32'h210);
      check_eq($sformatf("ext%0d_len", i), 32'(mem_bus.mem_len), lt_f3[i][0] ? 32'd1 : 32'd0);
      mem_complete(lt_rd[i]);
      check_eq($sformatf("ext%0d_val", i), ld_val, lt_exp[i]);
      check_eq($sformatf("ext%0d_tag", i), 32'(ld_robpos), 32'(8 + i));
    end

    // ---- stored-entry wakeup, duplicate tag: channel 0 wins ----
    push_op(1'b0, 3'b010, 32'h4, 4'd2, 32'd9, 32'h0, 1'b1, 1'b0);
    no_req("dup_wait", 3);
    wb_valid = 2'b11;
    wb_robpos = {4'd9, 4'd9};
    wb_val = {32'h0000_0400, 32'h0000_0300};
    @(negedge clk);
    wb_valid = '0;
    wait_req("dup");
    check_eq("dup_addr", mem_bus.mem_addr, 32'h304);
    mem_complete(32'h1);

    // ---- store waits for commit ----
    s0 = exp_tail;
    push_op(1'b1, 3'b010, 32'h8, 4'd1, 32'h1000, 32'hCAFE_F00D, 1'b0, 1'b0);
    no_req("sw_nocommit", 10);
    commit_valid = 1'b1;
    commit_lsbpos = IDX_W'(s0);
    @(negedge clk);
    commit_valid = 1'b0;
    wait_req("sw");
    check_eq("sw_we", 32'(mem_bus.mem_we), 32'd1);
    check_eq("sw_addr", mem_bus.mem_addr, 32'h1008);
    check_eq("sw_wdata", mem_bus.mem_wdata, 32'hCAFE_F00D);
    mem_complete(32'h0);
    check_eq("sw_no_ldv", 32'(ld_valid), 32'd0);
    check_eq("sw_count", 32'(count), 32'd0);

    // ---- I/O load held until ROB head ----
    rob_head_robpos = 4'd6;
    push_op(1'b0, 3'b010, 32'h0, 4'd7, 32'h0003_0000, 32'h0, 1'b0, 1'b0);
    no_req("io_hold", 5);
    rob_head_robpos = 4'd7;
    wait_req("io");
    check_eq("io_addr", mem_bus.mem_addr, 32'h0003_0000);
    mem_complete(32'h55);
    check_eq("io_val", ld_val, 32'h55);

    // ---- fill to full, commit two stores, flush during first store ----
    s0 = exp_tail;
    for (int i = 0; i < DEPTH; i++) begin
      if (i < 2)
        push_op(1'b1, 3'b010, 32'(4 * i), 4'd1, 32'h2000, 32'h1111_1111 * (i + 1), 1'b0, 1'b0);
      else
        push_op(1'b0, 3'b010, 32'h0, 4'd2, 32'd15, 32'h0, 1'b1, 1'b0);
      check_eq($sformatf("fill%0d_count", i), 32'(count), 32'(i + 1));
      check_eq($sformatf("fill%0d_afull", i), 32'(almost_full),
               32'((DEPTH - (i + 1)) <= AFULL_TH));
      check_eq($sformatf("fill%0d_full", i), 32'(full), 32'((i + 1) == DEPTH));
    end
    commit_valid = 1'b1;
    commit_lsbpos = IDX_W'(s0);
    @(negedge clk);
    commit_lsbpos = IDX_W'((s0 + 1) % DEPTH);
    @(negedge clk);
    commit_valid = 1'b0;
    wait_req("st0");
    check_eq("st0_we", 32'(mem_bus.mem_we), 32'd1);
    check_eq("st0_addr", mem_bus.mem_addr, 32'h2000);
    check_eq("st0_wdata", mem_bus.mem_wdata, 32'h1111_1111);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_tail = (s0 + 2) % DEPTH;
    check_eq("fl_count", 32'(count), 32'd2);
    check_eq("fl_tail", 32'(tail_pos), 32'(exp_tail));
    check_eq("fl_full", 32'(full), 32'd0);
    check_eq("fl_req_held", 32'(mem_bus.mem_req), 32'd1);
    mem_complete(32'h0);
    check_eq("st0_count", 32'(count), 32'd1);
    wait_req("st1");
    check_eq("st1_addr", mem_bus.mem_addr, 32'h2004);
    check_eq("st1_wdata", mem_bus.mem_wdata, 32'h2222_2222);
    mem_complete(32'h0);
    check_eq("st1_count", 32'(count), 32'd0);
    check_eq("st1_tail", 32'(tail_pos), 32'(exp_tail));

    // ---- flush during an in-flight load: drain ----
    push_op(1'b0, 3'b010, 32'h0, 4'd2, 32'h500, 32'h0, 1'b0, 1'b0);
    wait_req("drn");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_tail = (exp_tail + DEPTH - 1) % DEPTH;
    check_eq("drn_req_held", 32'(mem_bus.mem_req), 32'd1);
    check_eq("drn_count", 32'(count), 32'd0);
    check_eq("drn_tail", 32'(tail_pos), 32'(exp_tail));
    @(negedge clk);
    check_eq("drn_req_held2", 32'(mem_bus.mem_req), 32'd1);
    mem_complete(32'hFFFF);
    check_eq("drn_req_drop", 32'(mem_bus.mem_req), 32'd0);
    check_eq("drn_no_ldv", 32'(ld_valid), 32'd0);
    @(negedge clk);
    check_eq("drn_no_ldv2", 32'(ld_valid), 32'd0);
    push_op(1'b0, 3'b010, 32'h0, 4'd4, 32'h600, 32'h0, 1'b0, 1'b0);
    wait_req("after_drn");
    check_eq("after_drn_addr", mem_bus.mem_addr, 32'h600);
    mem_complete(32'h1234_5678);
    check_eq("after_drn_val", ld_val, 32'h1234_5678);
    check_eq("after_drn_tag", 32'(ld_robpos), 32'd4);

    // ---- flush with same-cycle mem_done on a load ----
    push_op(1'b0, 3'b010, 32'h0, 4'd5, 32'h700, 32'h0, 1'b0, 1'b0);
    wait_req("fd");
    flush = 1'b1;
    mem_bus.mem_done = 1'b1;
    mem_bus.mem_rdata = 32'hAAAA_AAAA;
    @(negedge clk);
    flush = 1'b0;
    mem_bus.mem_done = 1'b0;
    exp_tail = (exp_tail + DEPTH - 1) % DEPTH;
    check_eq("fd_req", 32'(mem_bus.mem_req), 32'd0);
    check_eq("fd_no_ldv", 32'(ld_valid), 32'd0);
    check_eq("fd_count", 32'(count), 32'd0);
    check_eq("fd_tail", 32'(tail_pos), 32'(exp_tail));
    push_op(1'b0, 3'b000, 32'h1, 4'd6, 32'h800, 32'h0, 1'b0, 1'b0);
    wait_req("after_fd");
    check_eq("after_fd_addr", mem_bus.mem_addr, 32'h801);
    mem_complete(32'h7F);
    check_eq("after_fd_val", ld_val, 32'h7F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsb_param.md
Name: lsb_param

Overview:
- Parametrised in-order load/store buffer; next generation of the core's LSB.
- Sits between issue, ROB and the memory controller; executes loads/stores strictly from the head, one memory access at a time.
- Adds over the previous LSB:
  - configurable depth and ROB tag width;
  - NUM_WB parallel writeback (wakeup) channels;
  - occupancy and almost-full outputs;
  - I/O-region loads held until ROB head;
  - flush that drains an in-flight access cleanly instead of abandoning it.

Parameters:
DEPTH, 16, entries; power of 2, >=2
ROB_W, 4, ROB tag width
NUM_WB, 2, writeback channels snooped for operand wakeup
AFULL_TH, 3, almost_full asserts when free entries <= AFULL_TH
IO_BASE, 32'h0003_0000, addresses >= IO_BASE are I/O

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset (0 = reset)
push  in  1  enqueue entry at tail
push_is_store  in  1  1 = store, 0 = load
push_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
push_imm  in  32  address offset
push_robpos  in  ROB_W  ROB tag of the instruction
push_vj/push_vk  in  32 each  base / store data, or producer tag in [ROB_W-1:0]
push_qj/push_qk  in  1 each  1 = operand still pending
wb_valid  in  NUM_WB  writeback strobes
wb_robpos  in  NUM_WB*ROB_W  writeback tags, channel k at [k*ROB_W +: ROB_W]
wb_val  in  NUM_WB*32  writeback values
commit_valid  in  1  ROB commits a store
commit_lsbpos  in  log2(DEPTH)  LSB index of the committed store
rob_head_robpos  in  ROB_W  tag at ROB head
flush  in  1  mispredict flush
mem_done  in  1  one-cycle completion from the memory controller
mem_rdata  in  32  load data, valid with mem_done
mem_req  out  1  access request, level
mem_we  out  1  1 = store
mem_addr  out  32  access address
mem_len  out  2  00 byte, 01 half, 11 word
mem_wdata  out  32  store data
ld_valid  out  1  load result pulse
ld_val  out  32  extended load data
ld_robpos  out  ROB_W  tag of the completed load
tail_pos  out  log2(DEPTH)  index the next push will occupy
count  out  log2(DEPTH)+1  occupied entries
full  out  1  count == DEPTH
almost_full  out  1  DEPTH-count <= AFULL_TH

Behaviour:
- Reset (async, reset=0):
  - head = tail = count = 0, state IDLE;
  - all outputs 0: mem_req, mem_we, ld_valid, full, almost_full, mem_addr, mem_len, mem_wdata, ld_val, ld_robpos.
  - Reset mid-access drops it; the memory controller is reset together with this block.
- Circular buffer, indices wrap DEPTH-1 -> 0.
  - count is registered; a push and a retire on the same edge leave count unchanged.
  - A push while full is illegal; the bench asserts it never occurs.
- Wakeup: every cycle, each valid entry with q=1 whose tag matches any valid wb channel takes that channel's value and clears q.
  - The lowest-index channel wins a duplicate match.
  - A push with q=1 whose tag matches a same-cycle wb is stored with q=0 and the forwarded value.
- Commit: commit_valid sets committed[commit_lsbpos]. A store never accesses memory before it is committed.
- Address: addr = vj + imm, mod 2^32.
- FSM states: IDLE, BUSY, DRAIN.
  - IDLE -> BUSY when the head entry is valid and qj = qk = 0, and:
    - a store is committed, or
    - a load has addr < IO_BASE, or
    - a load has addr >= IO_BASE and its robpos == rob_head_robpos.
  - On that edge mem_req = 1 and mem_we, mem_addr, mem_len, mem_wdata = vk are set; they are held stable until mem_done.
  - BUSY with mem_done:
    - mem_req = 0 and the head retires;
    - a load drives ld_valid = 1 for exactly one cycle, with ld_val extended per funct3 (B/H sign-extend, BU/HU zero-extend) and ld_robpos = the entry's tag;
    - the FSM returns to IDLE. At least one idle cycle follows before the next request.
- Flush:
  - Uncommitted entries are discarded: tail = head + number of committed entries. Committed entries always form a prefix from head.
  - In IDLE, the flush takes effect the same edge.
  - In BUSY on an uncommitted load, state goes to DRAIN. mem_req stays high until mem_done; the result is discarded (ld_valid stays 0). The load entry is not retained past flush (it is uncommitted); DRAIN only finishes the memory handshake, and a same-cycle mem_done takes this same path, dropping mem_req without ld_valid. The FSM then returns to IDLE.
  - In BUSY on a committed store, the store completes normally and retires.
  - push, commit and wb are ignored in the flush cycle. ld_valid is forced 0 in the flush cycle.

Test Plan:
- Reset held low mid-BUSY, then released -> all outputs 0, count=0, tail_pos=0, no mem_req.
- Push LW (vj=0x100, imm=4, qj=0, robpos=3); mem_done with rdata 0xDEADBEEF two cycles after mem_req -> mem_addr=0x104, mem_len=11, then ld_valid 1 cycle with ld_val=0xDEADBEEF, ld_robpos=3.
- Push LB with qj=1 tag 5; wb channel 1 delivers tag 5 value 0x200 in the same cycle; rdata=0x80 -> addr 0x200+imm, ld_val=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- Push SW, no commit for 10 cycles -> mem_req stays 0; commit_valid at its index -> mem_req, mem_we=1, mem_wdata=vk.
- LW to 0x30000 with robpos=7, rob_head_robpos=6 -> no request; head changes to 7 -> request issues.
- Push DEPTH entries -> full=1, almost_full from count=DEPTH-AFULL_TH. Commit 2 stores, flush while the first store is BUSY -> both stores complete, count=0 after, tail_pos = head after the stores.
- Flush during an in-flight load -> mem_req held until mem_done, no ld_valid, then IDLE.
